// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a DEPTH-entry result FIFO toward execute.
// Define IMMGEN_ILLEGAL_EN to add the per-entry illegal flag output.

module imm_gen_dec #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      typ,
  output logic            ill
);
  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6, T_SH = 3'd7;

  logic [2:0] f3;
  assign f3 = ir[14:12];

  // Full 7-bit opcode match: words with ir[1:0] != 2'b11 fall through to default.
  always_comb begin
    imm = '0;
    typ = T_NONE;
    ill = 1'b0;
    case (ir[6:0])
      7'b0110111, 7'b0010111: begin
        typ = T_U;
        imm = XLEN'($signed({ir[31:12], 12'b0}));
      end
      7'b1101111: begin
        typ = T_J;
        imm = XLEN'($signed({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      end
      7'b1100011: begin
        typ = T_B;
        imm = XLEN'($signed({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      end
      7'b0100011: begin
        typ = T_S;
        imm = XLEN'($signed({{20{ir[31]}}, ir[31:25], ir[11:7]}));
      end
      7'b1100111, 7'b0000011: begin
        typ = T_I;
        imm = XLEN'($signed({{20{ir[31]}}, ir[31:20]}));
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // shamt only; funct7 bits (e.g. SRAI bit 30) never reach the operand
          typ = T_SH;
          imm = (XLEN == 64) ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);
        end else begin
          typ = T_I;
          imm = XLEN'($signed({{20{ir[31]}}, ir[31:20]}));
        end
      end
      7'b1110011: begin
        if (f3[2]) begin
          typ = T_Z;
          imm = XLEN'(ir[19:15]);
        end
      end
      7'b0110011: ;
      default: ill = 1'b1;
    endcase
  end
endmodule

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immed,
  output logic [2:0]       imm_type,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ILLEGAL_EN
  ,
  output logic             illegal
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  imm_gen_dec #(.XLEN(XLEN)) u_dec (
    .ir  (ir),
    .imm (wr_entry.imm),
    .typ (wr_entry.typ),
    .ill (wr_entry.ill)
  );
  assign wr_entry.tag = in_tag;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head     = out_valid ? mem[rd_ptr] : '0;
  assign immed    = head.imm;
  assign imm_type = head.typ;
  assign out_tag  = head.tag;

`ifdef IMMGEN_ILLEGAL_EN
  assign illegal = head.ill;
`else
  logic unused_ill;
  assign unused_ill = head.ill;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: vector table, handshake/flush/reset sequences, randomized model check.
module tb_imm_gen_pipe;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [7:0]  in_tag = '0;

  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] immed;
  logic [63:0] immed64;
  logic [2:0]  imm_type, imm_type64;
  logic [7:0]  out_tag, out_tag64;
`ifdef IMMGEN_ILLEGAL_EN
  logic        illegal, illegal64;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(8)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .immed(immed), .imm_type(imm_type), .out_tag(out_tag)
`ifdef IMMGEN_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(8)) dut64 (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .ir(ir), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .immed(immed64), .imm_type(imm_type64), .out_tag(out_tag64)
`ifdef IMMGEN_ILLEGAL_EN
    , .illegal(illegal64)
`endif
  );

  typedef struct {
    logic [63:0] v64;
    logic [31:0] v32;
    logic [2:0]  t;
    logic        ill;
    logic [7:0]  tag;
  } ref_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  t;
    logic        ill;
  } vec_t;

  vec_t vecs[11];
  ref_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the format rules, using signed 64-bit arithmetic.
  function automatic ref_t ref_dec(input logic [31:0] w);
    ref_t   r;
    longint sw, v;
    sw = longint'($signed(w));
    v = 0;
    r.t = 3'd0;
    r.ill = 1'b0;
    r.tag = '0;
    r.v64 = '0;
    r.v32 = '0;
    case (w[6:0])
      7'h37, 7'h17: begin r.t = 3'd4; v = (sw >>> 12) * 4096; end
      7'h6F: begin
        r.t = 3'd5;
        v = (sw >>> 31) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2;
      end
      7'h63: begin
        r.t = 3'd3;
        v = (sw >>> 31) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2;
      end
      7'h23: begin r.t = 3'd2; v = (sw >>> 25) * 32 + longint'(w[11:7]); end
      7'h67, 7'h03: begin r.t = 3'd1; v = sw >>> 20; end
      7'h13: begin
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
          r.t = 3'd7;
          r.v64 = 64'(w[25:20]);
          r.v32 = 32'(w[24:20]);
          return r;
        end
        r.t = 3'd1;
        v = sw >>> 20;
      end
      7'h73: if (w[14]) begin r.t = 3'd6; v = longint'(w[19:15]); end
      7'h33: ;
      default: r.ill = 1'b1;
    endcase
    r.v64 = 64'(v);
    r.v32 = r.v64[31:0];
    return r;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [6:0]  ops[12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h13};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  task automatic chk_head_idle();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_immed", 64'(immed), 64'd0);
    chk("idle_immed64", immed64, 64'd0);
    chk("idle_type", 64'(imm_type), 64'd0);
    chk("idle_tag", 64'(out_tag), 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
    chk("idle_illegal", 64'(illegal), 64'd0);
`endif
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h008000EF, 32'h00000008, 64'h0000000000000008, 3'd5, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[3]  = '{32'h4030D093, 32'h00000003, 64'h0000000000000003, 3'd7, 1'b0};
    vecs[4]  = '{32'h00509093, 32'h00000005, 64'h0000000000000005, 3'd7, 1'b0};
    vecs[5]  = '{32'h3002D073, 32'h00000005, 64'h0000000000000005, 3'd6, 1'b0};
    vecs[6]  = '{32'h80001037, 32'h80001000, 64'hFFFFFFFF80001000, 3'd4, 1'b0};
    vecs[7]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[8]  = '{32'h00000033, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[9]  = '{32'h00000073, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[10] = '{32'h00000000, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1};
    w0 = 32'h00100093;
    w1 = 32'h00200093;
    w2 = 32'h00300093;

    // reset state
    @(negedge CLK);
    chk_head_idle();
    RST = 1'b0;

    // vector table, one-cycle latency with out_ready high
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      in_valid = 1'b1; ir = vecs[i].ir; in_tag = 8'(i + 1); out_ready = 1'b1;
      @(posedge CLK); #1;
      chk("vec_out_valid", 64'(out_valid), 64'd1);
      chk("vec_immed", 64'(immed), 64'(vecs[i].e32));
      chk("vec_immed64", immed64, vecs[i].e64);
      chk("vec_type", 64'(imm_type), 64'(vecs[i].t));
      chk("vec_type64", 64'(imm_type64), 64'(vecs[i].t));
      chk("vec_tag", 64'(out_tag), 64'(i + 1));
`ifdef IMMGEN_ILLEGAL_EN
      chk("vec_illegal", 64'(illegal), 64'(vecs[i].ill));
`endif
      in_valid = 1'b0;
    end
    @(posedge CLK); #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // backpressure: fill, hold third word, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; ir = w0; in_tag = 8'd10;
    chk("bp_ready0", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    chk("bp_tag_first", 64'(out_tag), 64'd10);
    ir = w1; in_tag = 8'd11;
    chk("bp_ready1", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    ir = w2; in_tag = 8'd12;
    @(posedge CLK); #1;
    chk("bp_held_ready", 64'(in_ready), 64'd0);
    chk("bp_held_tag", 64'(out_tag), 64'd10);
    chk("bp_held_immed", 64'(immed), 64'd1);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_pop1_tag", 64'(out_tag), 64'd11);
    chk("bp_pop1_immed", 64'(immed), 64'd2);
    chk("bp_pop1_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    chk("bp_pushpop_valid", 64'(out_valid), 64'd1);
    chk("bp_pushpop_ready", 64'(in_ready), 64'd1);
    chk("bp_pushpop_tag", 64'(out_tag), 64'd12);
    chk("bp_pushpop_immed", 64'(immed), 64'd3);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("bp_empty", 64'(out_valid), 64'd0);

    // flush with two entries buffered and in_valid high
    out_ready = 1'b0; in_valid = 1'b1; ir = w0; in_tag = 8'd20;
    @(posedge CLK); #1;
    ir = w1; in_tag = 8'd21;
    @(posedge CLK); #1;
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; ir = w2; in_tag = 8'd22;
    @(posedge CLK); #1;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("fl_dropped", 64'(out_valid), 64'd0);
    // flush at count 1 beats a simultaneous push and pop
    in_valid = 1'b1; ir = w0; in_tag = 8'd23;
    @(posedge CLK); #1;
    flush = 1'b1; out_ready = 1'b1; ir = w1; in_tag = 8'd24;
    @(posedge CLK); #1;
    chk("fl_pushpop_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("fl_pushpop_after", 64'(out_valid), 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; ir = w0; in_tag = 8'd30;
    @(posedge CLK); #1;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    ir = w1; in_tag = 8'd31;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk_head_idle();
    ir = w2; in_tag = 8'd32;
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_first_push_valid", 64'(out_valid), 64'd1);
    chk("rst_first_push_tag", 64'(out_tag), 64'd32);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("rst_drain", 64'(out_valid), 64'd0);

    // randomized traffic against the queue model
    q.delete();
    for (int n = 0; n < 600; n++) begin
      ref_t r;
      int   sz;
      bit   push, pop;
      @(negedge CLK);
      sz = q.size();
      chk("rnd_out_valid", 64'(out_valid), 64'(sz != 0));
      chk("rnd_in_ready", 64'(in_ready), 64'(sz < DEPTH));
      chk("rnd_in_ready64", 64'(in_ready64), 64'(sz < DEPTH));
      if (sz != 0) begin
        chk("rnd_immed", 64'(immed), 64'(q[0].v32));
        chk("rnd_immed64", immed64, q[0].v64);
        chk("rnd_type", 64'(imm_type), 64'(q[0].t));
        chk("rnd_tag", 64'(out_tag), 64'(q[0].tag));
        chk("rnd_tag64", 64'(out_tag64), 64'(q[0].tag));
`ifdef IMMGEN_ILLEGAL_EN
        chk("rnd_illegal", 64'(illegal), 64'(q[0].ill));
`endif
      end else begin
        chk("rnd_empty_immed", 64'(immed), 64'd0);
        chk("rnd_empty_type", 64'(imm_type64), 64'd0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      ir        = rand_ir();
      in_tag    = 8'($urandom);
      push = in_valid && (sz < DEPTH) && !flush;
      pop  = (sz != 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          r = ref_dec(ir);
          r.tag = in_tag;
          q.push_back(r);
        end
      end
    end

    @(negedge CLK);
    in_valid = 1'b0; flush = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one 32-bit instruction word per cycle over a valid/ready handshake. Decodes the immediate, sign- or zero-extended to XLEN, with its format class, and buffers results in a DEPTH-entry FIFO toward the execute-stage operand muxes. Adds shift-amount and CSR-zimm formats, a pass-through tag, and a pipeline flush.

## Interface
Parameters:
- XLEN, 32: immediate width; legal values are 32 and 64.
- DEPTH, 2: result FIFO entries; must be a power of two and at least 2.
- TAG_W, 8: width of the sideband tag (PC index/ROB id) carried with each result.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all buffered results.
- in_valid  in  1  ir/in_tag valid.
- in_ready  out  1  FIFO can accept this cycle.
- ir  in  32  instruction word.
- in_tag  in  TAG_W  sideband, returned unmodified.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head this cycle.
- immed  out  XLEN  decoded immediate at head.
- imm_type  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shamt).
- out_tag  out  TAG_W  tag at head.
- illegal  out  1  present only with IMMGEN_ILLEGAL_EN.

## Operation
- Decode is combinational on ir. The result is written to the FIFO tail on a push, where push = in_valid && in_ready && !flush.
- LUI and AUIPC are U: {ir[31:12],12'b0}, sign-extended from bit 31.
- JAL is J: {ir[31],ir[19:12],ir[20],ir[30:21],1'b0}, sign-extended.
- BRANCH is B: {ir[31],ir[7],ir[30:25],ir[11:8],1'b0}, sign-extended.
- STORE is S: {ir[31:25],ir[11:7]}, sign-extended.
- JALR and LOAD are I: ir[31:20], sign-extended.
- OP_IMM uses I, except funct3 001/101, which is SH:
  - SH immed is the zero-extended shamt: ir[24:20] when XLEN=32, ir[25:20] when XLEN=64.
  - The funct7 bits (e.g. SRAI bit 30) are masked off.
- SYS with funct3[2]=1 is Z: immed is the zero-extended ir[19:15].
- Everything else, including OP_RG3 and SYS with funct3[2]=0, is NONE with immed 0.
- FIFO behaviour:
  - A pop occurs when out_valid && out_ready.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH). It is registered-state-only, with no combinational path from out_ready.
- out_valid = (count != 0). immed, imm_type and out_tag show the head entry and are held stable while out_valid && !out_ready.
- With flush=1, count and pointers are zeroed at the next edge. Any same-cycle push and pop are discarded, so flush wins.
- Reset values: count 0, pointers 0, out_valid 0, in_ready 1, immed 0, imm_type 0, out_tag 0, illegal 0.

## Timing
- Latency is one cycle. An instruction accepted at edge N is at the head (when the FIFO was empty) with out_valid=1 after edge N.
- Throughput is one instruction per cycle when out_ready is held high.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. A pop that cycle raises in_ready the following cycle.
- Empty: out_valid=0 and head outputs read 0. An out_ready asserted while empty has no effect.
- RST asserted mid-stream: all state clears immediately (asynchronously), and buffered entries are lost. The first push is accepted on the first rising edge after RST deasserts.

## Configuration
- IMMGEN_ILLEGAL_EN defined:
  - Adds the illegal output, stored per entry.
  - illegal=1 when ir[1:0]!=2'b11 or the opcode is not one of the ten base opcodes. Such entries have immed 0 and imm_type NONE.
- Not defined:
  - The port is absent.
  - These words decode as NONE with immed 0.

## Test plan
- XLEN=32, DEPTH=2, out_ready=1:
  - ir 0xFFF00093 -> immed 0xFFFFFFFF, type I.
  - ir 0x008000EF -> immed 0x00000008, type J.
  - ir 0xFE000EE3 -> immed 0xFFFFFFFC, type B.
  - Each appears one cycle after acceptance.
- Shift/CSR:
  - ir 0x4030D093 -> immed 3, type SH.
  - ir 0x00509093 -> immed 5, type SH.
  - ir 0x3002D073 -> immed 5, type Z.
  - XLEN=64, ir 0x80001037 (LUI) -> immed 0xFFFFFFFF80001000.
- Backpressure, DEPTH=2:
  - out_ready=0 and push 3 words -> in_ready=0 after 2 accepts, third word held by source.
  - out_ready=1 -> words emerge in order with matching out_tag, and in_ready returns high one cycle after the first pop.
- Simultaneous push/pop at count=1 -> count remains 1 and order is preserved.
- Flush:
  - With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count 0, and the pushed word is dropped.
  - RST pulsed mid-stream -> all outputs return to 0 asynchronously.
- IMMGEN_ILLEGAL_EN:
  - ir 0x00000000 -> illegal=1, immed 0, type NONE.
  - ir 0x00000033 (OP_RG3) -> illegal=0, type NONE.
